// File: rtl/mul_div_sequencer.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// One shared 33-bit add/subtract path, iterated one bit per cycle (shift-add / restoring divide).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting; MTHI/MTLO write here, mult/div operands latched
//   S_PREP | take operand magnitudes, record result signs, clear work
//   S_ITER | 32 iterations, counter 31 -> 0
//   S_FIX  | apply signs, write HI/LO, pulse done
module mul_div_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] work_q, work_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [2:0]  op_q, op_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_mul, is_sgn, md_req, a_neg, b_neg;
   logic [32:0] add_lhs, add_rhs;
   logic [33:0] add_sum;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   assign is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);
   assign is_sgn = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign md_req = start && !cancel && (op >= OP_MULT) && (op <= OP_DIVU);
   assign a_neg  = is_sgn && opa_q[31];
   assign b_neg  = is_sgn && opb_q[31];

   // Shared path: accumulate multiplicand, or trial-subtract divisor (bit 33 = no borrow).
   assign add_lhs = is_mul ? {1'b0, work_q[63:32]} : {work_q[63:32], opa_q[31]};
   assign add_rhs = is_mul ? (opb_q[0] ? {1'b0, opa_q} : 33'd0) : ~{1'b0, opb_q};
   assign add_sum = {1'b0, add_lhs} + {1'b0, add_rhs} + {33'd0, ~is_mul};

   assign prod = neg_q ? -work_q : work_q;
   assign quo  = dz_q ? 32'hFFFF_FFFF : (neg_q ? -work_q[31:0] : work_q[31:0]);
   assign rem  = rneg_q ? -work_q[63:32] : work_q[63:32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      op_d    = op_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !cancel && op == OP_MTHI) hi_d = a;
            if (start && !cancel && op == OP_MTLO) lo_d = a;
         end
         S_PREP: begin
            opa_d   = a_neg ? -opa_q : opa_q;
            opb_d   = b_neg ? -opb_q : opb_q;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (opb_q == 32'd0);
            work_d  = 64'd0;
            cnt_d   = 5'd31;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (is_mul) begin
               work_d = {add_sum[32:0], work_q[31:1]};
               opb_d  = opb_q >> 1;
            end else begin
               work_d = {(add_sum[33] ? add_sum[31:0] : add_lhs[31:0]), work_q[30:0], add_sum[33]};
               opa_d  = opa_q << 1;
            end
            if (cnt_q == 5'd0) state_d = S_FIX;
            else               cnt_d   = cnt_q - 5'd1;
         end
         S_FIX: begin
            hi_d    = is_mul ? prod[63:32] : rem;
            lo_d    = is_mul ? prod[31:0]  : quo;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // FIX accepts the next mult/div so back-to-back issue has no bubble.
      if ((state_q == S_IDLE || state_q == S_FIX) && md_req) begin
         opa_d   = a;
         opb_d   = b;
         op_d    = op;
         state_d = S_PREP;
      end

      if (cancel && state_q != S_IDLE) begin
         state_d = S_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         work_q  <= 64'd0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         op_q    <= 3'd0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: expected HI/LO pushed at issue, popped on done.
module tb_mul_div_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_chk = 0;
   int n_err = 0;
   logic [63:0] sb[$];

   mul_div_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .cancel  (cancel),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model, returns {hi, lo}.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [31:0] q, r;
      case (o)
         3'd1: return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
         3'd2: return {32'd0, x} * {32'd0, y};
         3'd3: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
         end
         3'd4: begin
            if (y == 32'd0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: return 64'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("hi", 64'(hi), 64'(e[63:32]));
            chk("lo", 64'(lo), 64'(e[31:0]));
         end
      end
   end

   // Called just after a rising edge; the next rising edge samples the request.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'd0;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (n < 200) begin
         @(negedge clk);
         if (done) break;
         if (busy) nbusy++;
         n++;
      end
   endtask

   task automatic mdop(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int n, nb;
      sb.push_back(model(o, x, y));
      issue(o, x, y);
      wait_done(n, nb);
      chk("latency", 64'(n), 64'd34);
      chk("busy_len", 64'(nb), 64'd34);
      chk("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_width", 64'(done), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n, nb;
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      a       = 32'd0;
      b       = 32'd0;
      cancel  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      mdop(3'd1, 32'hFFFF_FFFD, 32'd5);
      chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

      // MULTU then DIVU sampled on the very edge the first result lands
      sb.push_back(model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (33) @(posedge clk);
      #1;
      sb.push_back(model(3'd4, 32'd100, 32'd7));
      start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
      @(negedge clk);
      chk("b2b_done", 64'(done), 64'd1);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("multu_ff", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      wait_done(n, nb);
      chk("b2b_latency", 64'(n), 64'd33);
      chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
      @(posedge clk);
      #1;

      mdop(3'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      mdop(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      mdop(3'd4, 32'h1234_5678, 32'd0);
      chk("divu_by0", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
      mdop(3'd3, 32'hFFFF_FF00, 32'd0);
      mdop(3'd1, 32'h8000_0000, 32'h8000_0000);

      for (int i = 0; i < 10; i++) begin
         logic [31:0] x, y;
         logic [2:0]  o;
         o = 3'($urandom_range(1, 4));
         x = $urandom;
         y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i % 3 == 0) y = -y;
         mdop(o, x, y);
      end

      issue(3'd5, 32'hAAAA_5555, 32'd0);
      @(negedge clk);
      chk("mthi", 64'(hi), 64'hAAAA_5555);
      chk("mthi_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      issue(3'd6, 32'h0F0F_0F0F, 32'd0);
      @(negedge clk);
      chk("mtlo", 64'(lo), 64'h0F0F_0F0F);
      @(posedge clk);
      #1;

      cancel = 1'b1;
      issue(3'd5, 32'h1111_1111, 32'd0);
      cancel = 1'b0;
      @(negedge clk);
      chk("cancel_beats_start", 64'(hi), 64'hAAAA_5555);
      @(posedge clk);
      #1;

      issue(3'd1, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      @(negedge clk);
      chk("cancel_busy", 64'(busy), 64'd0);
      chk("cancel_hilo", {hi, lo}, 64'hAAAA_5555_0F0F_0F0F);
      repeat (40) @(posedge clk);
      #1;
      chk("cancel_hilo_late", {hi, lo}, 64'hAAAA_5555_0F0F_0F0F);

      sb.push_back(model(3'd1, 32'd7, 32'hFFFF_FFFE));
      issue(3'd1, 32'd7, 32'hFFFF_FFFE);
      repeat (5) @(posedge clk);
      #1;
      issue(3'd6, 32'h1234_5678, 32'd0);
      @(negedge clk);
      chk("mtlo_while_busy", 64'(lo), 64'h0F0F_0F0F);
      wait_done(n, nb);
      chk("mtlo_busy_latency", 64'(n), 64'd27);
      @(posedge clk);
      #1;

      issue(3'd5, 32'hAAAA_5555, 32'd0);
      issue(3'd6, 32'h0F0F_0F0F, 32'd0);
      issue(3'd1, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      chk("async_rst_hilo", {hi, lo}, 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      mdop(3'd1, 32'd2, 32'd3);
      chk("mult_2x3", {hi, lo}, 64'd6);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
